// File: rtl/layer_mux_pkg.sv
// Purpose: shared types, constants and helpers for the layer priority mux family.
// Latency: n/a (package only).
// Backpressure: n/a; no flow control in the pixel path.
package layer_mux_pkg;

    localparam int MAX_LAYERS  = 8;
    localparam int LAYER_IDX_W = 3;

    typedef logic [7:0] rgb_t;

    // Clearing the lowest set bit leaves something behind only when two or
    // more bits were set.
    function automatic logic popcount_ge2(input logic [MAX_LAYERS-1:0] v);
        return |(v & (v - 8'd1));
    endfunction

endpackage

// File: rtl/layer_priority_encoder.sv
// Purpose: fixed-priority encoder over a layer request vector (bit 0 wins).
// Latency: combinational.
// Backpressure: none.
// Ports: eff_i request vector; winner_o lowest set index (0 when none);
//        valid_o any bit set; ge2_o two or more bits set.
module layer_priority_encoder
    import layer_mux_pkg::*;
#(
    parameter int NUM_LAYERS = 4
) (
    input  logic [NUM_LAYERS-1:0]  eff_i,
    output logic [LAYER_IDX_W-1:0] winner_o,
    output logic                   valid_o,
    output logic                   ge2_o
);

    logic [MAX_LAYERS-1:0] eff_ext;

    always_comb begin
        eff_ext = '0;
        eff_ext[NUM_LAYERS-1:0] = eff_i;
    end

    // Walk from the highest index down so the lowest set index is the last
    // assignment and therefore wins.
    always_comb begin
        winner_o = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_i[i]) begin
                winner_o = LAYER_IDX_W'(i);
            end
        end
    end

    assign valid_o = |eff_i;
    assign ge2_o   = popcount_ge2(eff_ext);

endmodule

// File: rtl/layer_priority_mux.sv
// Purpose: N-layer VGA pixel mux with transparency key, frame-synchronous enables, collision tracking.
// Latency: 2 clocks for every pixel output; frameDone/frameCollisionMask 1 clock after startOfFrame.
// Backpressure: none; a new pixel is accepted every clock.
// Ports: clk/resetN; startOfFrame; layerReq/layerRGB/layerEnableNext per layer;
//        BGDrawingRequest/backGroundRGB; RGB_MIF fallback; RGBOut, winnerLayer,
//        winnerValid, pixelCollision per pixel; frameCollisionMask/frameDone per frame.
module layer_priority_mux
    import layer_mux_pkg::*;
#(
    parameter int   NUM_LAYERS      = 4,
    parameter rgb_t TRANSPARENT_RGB = 8'hFF,
    parameter int   KEY_ENABLE      = 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [NUM_LAYERS-1:0]   layerReq,
    input  logic [NUM_LAYERS*8-1:0] layerRGB,
    input  logic [NUM_LAYERS-1:0]   layerEnableNext,
    input  logic                    BGDrawingRequest,
    input  logic [7:0]              backGroundRGB,
    input  logic [7:0]              RGB_MIF,
    output logic [7:0]              RGBOut,
    output logic [2:0]              winnerLayer,
    output logic                    winnerValid,
    output logic                    pixelCollision,
    output logic [NUM_LAYERS-1:0]   frameCollisionMask,
    output logic                    frameDone
);

    // Reset asserts asynchronously and releases on the second clock edge.
    logic rst_meta_q, rst_n_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Stage 1: effective (enabled, opaque, requested) layer vector.
    logic [NUM_LAYERS-1:0]   enable_q, enable_d, en_cur;
    logic [NUM_LAYERS-1:0]   eff_d, eff_q;
    logic [NUM_LAYERS*8-1:0] rgb_q;
    logic                    bg_req_q;
    rgb_t                    bg_rgb_q, mif_q;

    // The start-of-frame pixel already uses the enables that take effect
    // for the new frame.
    assign en_cur   = startOfFrame ? layerEnableNext : enable_q;
    assign enable_d = en_cur;

    always_comb begin
        eff_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff_d[i] = layerReq[i] & en_cur[i] &
                       ((KEY_ENABLE == 0) || (layerRGB[8*i +: 8] != TRANSPARENT_RGB));
        end
    end

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            enable_q <= '1;
            eff_q    <= '0;
            rgb_q    <= '0;
            bg_req_q <= 1'b0;
            bg_rgb_q <= '0;
            mif_q    <= '0;
        end else begin
            enable_q <= enable_d;
            eff_q    <= eff_d;
            rgb_q    <= layerRGB;
            bg_req_q <= BGDrawingRequest;
            bg_rgb_q <= backGroundRGB;
            mif_q    <= RGB_MIF;
        end
    end

    // Stage 2: priority select and collision.
    logic [LAYER_IDX_W-1:0] win_idx;
    logic                   win_vld, win_ge2;

    layer_priority_encoder #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_enc (
        .eff_i    (eff_q),
        .winner_o (win_idx),
        .valid_o  (win_vld),
        .ge2_o    (win_ge2)
    );

    rgb_t layer_sel, rgb_d;

    always_comb begin
        layer_sel = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (win_idx == LAYER_IDX_W'(i)) begin
                layer_sel = rgb_q[8*i +: 8];
            end
        end
        if (win_vld) begin
            rgb_d = layer_sel;
        end else if (bg_req_q) begin
            rgb_d = bg_rgb_q;
        end else begin
            rgb_d = mif_q;
        end
    end

    // The pixel currently in stage 2 still belongs to the outgoing frame when
    // startOfFrame arrives, so it is folded into the published mask directly.
    logic [NUM_LAYERS-1:0] coll_d, acc_d, acc_q;

    assign coll_d = win_ge2 ? eff_q : '0;
    assign acc_d  = startOfFrame ? '0 : (acc_q | coll_d);

    rgb_t                  rgb_out_q;
    logic [2:0]            winner_q;
    logic                  winner_vld_q, pix_coll_q, frame_done_q;
    logic [NUM_LAYERS-1:0] frame_mask_q;

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            rgb_out_q    <= '0;
            winner_q     <= '0;
            winner_vld_q <= 1'b0;
            pix_coll_q   <= 1'b0;
            acc_q        <= '0;
            frame_mask_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            rgb_out_q    <= rgb_d;
            winner_q     <= win_idx;
            winner_vld_q <= win_vld;
            pix_coll_q   <= win_ge2;
            acc_q        <= acc_d;
            frame_done_q <= startOfFrame;
            if (startOfFrame) begin
                frame_mask_q <= acc_q | coll_d;
            end
        end
    end

    assign RGBOut             = rgb_out_q;
    assign winnerLayer        = winner_q;
    assign winnerValid        = winner_vld_q;
    assign pixelCollision     = pix_coll_q;
    assign frameCollisionMask = frame_mask_q;
    assign frameDone          = frame_done_q;

endmodule

// File: tb/tb_layer_priority_mux.sv
// Purpose: scoreboard bench for layer_priority_mux (keyed and unkeyed instances).
// Latency: expects pixel outputs 2 clocks and frame outputs 1 clock after drive.
// Backpressure: none; one directed pixel per clock.
module tb_layer_priority_mux;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [3:0]  layerReq = '0;
    logic [31:0] layerRGB = '0;
    logic [3:0]  layerEnableNext = 4'hF;
    logic        BGDrawingRequest = 1'b0;
    logic [7:0]  backGroundRGB = '0;
    logic [7:0]  RGB_MIF = '0;

    logic [7:0] RGBOut, RGBOut_nk;
    logic [2:0] winnerLayer, winnerLayer_nk;
    logic       winnerValid, winnerValid_nk;
    logic       pixelCollision, pixelCollision_nk;
    logic [3:0] frameCollisionMask, frameCollisionMask_nk;
    logic       frameDone, frameDone_nk;

    layer_priority_mux #(.NUM_LAYERS(4), .TRANSPARENT_RGB(8'hFF), .KEY_ENABLE(1)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .layerReq(layerReq),
        .layerRGB(layerRGB), .layerEnableNext(layerEnableNext),
        .BGDrawingRequest(BGDrawingRequest), .backGroundRGB(backGroundRGB), .RGB_MIF(RGB_MIF),
        .RGBOut(RGBOut), .winnerLayer(winnerLayer), .winnerValid(winnerValid),
        .pixelCollision(pixelCollision), .frameCollisionMask(frameCollisionMask),
        .frameDone(frameDone)
    );

    layer_priority_mux #(.NUM_LAYERS(4), .TRANSPARENT_RGB(8'hFF), .KEY_ENABLE(0)) dut_nk (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .layerReq(layerReq),
        .layerRGB(layerRGB), .layerEnableNext(layerEnableNext),
        .BGDrawingRequest(BGDrawingRequest), .backGroundRGB(backGroundRGB), .RGB_MIF(RGB_MIF),
        .RGBOut(RGBOut_nk), .winnerLayer(winnerLayer_nk), .winnerValid(winnerValid_nk),
        .pixelCollision(pixelCollision_nk), .frameCollisionMask(frameCollisionMask_nk),
        .frameDone(frameDone_nk)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      tag;
        logic [7:0] rgb;
        logic [7:0] rgb_nk;
        logic [2:0] wl;
        logic       wv;
        logic       pc;
    } pix_t;

    typedef struct {
        int         due;
        logic [3:0] mask;
    } frm_t;

    pix_t pq[$];
    frm_t fq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the scoreboard says is due this cycle.
    always @(negedge clk) begin : mon
        pix_t e;
        frm_t f;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            e = pq.pop_front();
            chk({e.tag, " RGBOut"},         {24'h0, RGBOut},        {24'h0, e.rgb});
            chk({e.tag, " winnerValid"},    {31'h0, winnerValid},   {31'h0, e.wv});
            chk({e.tag, " winnerLayer"},    {29'h0, winnerLayer},   {29'h0, e.wl});
            chk({e.tag, " pixelCollision"}, {31'h0, pixelCollision}, {31'h0, e.pc});
            chk({e.tag, " RGBOut nokey"},   {24'h0, RGBOut_nk},     {24'h0, e.rgb_nk});
        end
        if (fq.size() > 0 && fq[0].due == cyc) begin
            f = fq.pop_front();
            chk("frameDone pulse", {31'h0, frameDone}, 32'h1);
            chk("frameCollisionMask", {28'h0, frameCollisionMask}, {28'h0, f.mask});
        end else begin
            chk("frameDone idle", {31'h0, frameDone}, 32'h0);
        end
    end

    // Drive one pixel and enqueue its hand-computed results.
    task automatic px(input string tag, input logic sof, input logic [3:0] en,
                      input logic [3:0] req, input logic [31:0] rgb,
                      input logic bg, input logic [7:0] bgc, input logic [7:0] mif,
                      input logic [7:0] e_rgb, input logic [7:0] e_nk,
                      input logic [2:0] e_wl, input logic e_wv, input logic e_pc,
                      input logic [3:0] e_mask);
        pix_t p;
        frm_t f;
        @(negedge clk);
        startOfFrame     = sof;
        layerEnableNext  = en;
        layerReq         = req;
        layerRGB         = rgb;
        BGDrawingRequest = bg;
        backGroundRGB    = bgc;
        RGB_MIF          = mif;
        p.due = cyc + 2; p.tag = tag; p.rgb = e_rgb; p.rgb_nk = e_nk;
        p.wl = e_wl; p.wv = e_wv; p.pc = e_pc;
        pq.push_back(p);
        if (sof) begin
            f.due = cyc + 1; f.mask = e_mask;
            fq.push_back(f);
        end
    endtask

    task automatic idle();
        px("idle", 1'b0, 4'hF, 4'h0, 32'h0, 1'b0, 8'h00, 8'h1C, 8'h1C, 8'h1C, 3'd0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((pq.size() > 0 || fq.size() > 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (pq.size() > 0 || fq.size() > 0) begin
            errors++;
            $display("FAIL drain timeout: got %0d pending expected 0", pq.size() + fq.size());
            pq.delete();
            fq.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " RGBOut"},             {24'h0, RGBOut},             32'h0);
        chk({tag, " winnerLayer"},        {29'h0, winnerLayer},        32'h0);
        chk({tag, " winnerValid"},        {31'h0, winnerValid},        32'h0);
        chk({tag, " pixelCollision"},     {31'h0, pixelCollision},     32'h0);
        chk({tag, " frameCollisionMask"}, {28'h0, frameCollisionMask}, 32'h0);
        chk({tag, " frameDone"},          {31'h0, frameDone},          32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Initial reset, with a startOfFrame that must be ignored.
        repeat (3) @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);

        //  tag        sof  en     req    rgb {l3,l2,l1,l0}  bg  bgc    mif    rgb    nokey  wl  wv  pc  mask
        px("mif",      0, 4'hF, 4'h0, 32'h0000_0000, 0, 8'h00, 8'h1C, 8'h1C, 8'h1C, 3'd0, 0, 0, 4'h0);
        px("l1_over",  0, 4'hF, 4'h6, 32'h0003_E000, 0, 8'h00, 8'h1C, 8'hE0, 8'hE0, 3'd1, 1, 1, 4'h0);
        px("key_bg",   0, 4'hF, 4'h1, 32'h0000_00FF, 1, 8'h92, 8'h1C, 8'h92, 8'hFF, 3'd0, 0, 0, 4'h0);
        px("en_mid",   0, 4'hE, 4'h3, 32'h0000_4020, 0, 8'h00, 8'h1C, 8'h20, 8'h20, 3'd0, 1, 1, 4'h0);
        px("en_sof",   1, 4'hE, 4'h3, 32'h0000_4020, 0, 8'h00, 8'h1C, 8'h40, 8'h40, 3'd1, 1, 0, 4'h7);
        px("en_hold",  0, 4'hF, 4'h3, 32'h0000_4020, 0, 8'h00, 8'h1C, 8'h40, 8'h40, 3'd1, 1, 0, 4'h0);
        px("en_all",   1, 4'hF, 4'h0, 32'h0000_0000, 0, 8'h00, 8'h1C, 8'h1C, 8'h1C, 3'd0, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            px("ov03",  0, 4'hF, 4'h9, 32'h3300_0055, 0, 8'h00, 8'h1C, 8'h55, 8'h55, 3'd0, 1, 1, 4'h0);
        end
        px("sof_l2",   1, 4'hF, 4'h4, 32'h0007_0000, 0, 8'h00, 8'h1C, 8'h07, 8'h07, 3'd2, 1, 0, 4'h9);
        px("sof_b2b",  1, 4'hF, 4'h0, 32'h0000_0000, 0, 8'h00, 8'h1C, 8'h1C, 8'h1C, 3'd0, 0, 0, 4'h0);
        px("all_key",  0, 4'hF, 4'hF, 32'hFFFF_FFFF, 1, 8'h92, 8'h1C, 8'h92, 8'hFF, 3'd0, 0, 0, 4'h0);
        px("ov23",     0, 4'hF, 4'hC, 32'h0AC0_0000, 1, 8'h92, 8'h1C, 8'hC0, 8'hC0, 3'd2, 1, 1, 4'h0);
        px("sof_23",   1, 4'hF, 4'h0, 32'h0000_0000, 0, 8'h00, 8'h1C, 8'h1C, 8'h1C, 3'd0, 0, 0, 4'hC);
        px("ov23b",    0, 4'hF, 4'hC, 32'h0AC0_0000, 0, 8'h00, 8'h1C, 8'hC0, 8'hC0, 3'd2, 1, 1, 4'h0);
        idle();
        idle();
        drain();

        // Mid-frame reset after an overlap: everything clears.
        resetN = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        px("post_rst", 1, 4'hF, 4'h0, 32'h0000_0000, 0, 8'h00, 8'h1C, 8'h1C, 8'h1C, 3'd0, 0, 0, 4'h0);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
